// File: rtl/xor_path_sched_pkg.sv
// Shared types and default sizing for the XOR/INV path scheduler.
// Holds the controller state encoding used by the top level.
package xor_path_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/xor_path_sched_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is used.
module rr_arbiter
    import xor_path_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    // Two passes avoid modular arithmetic: indices at/after ptr win first,
    // then the wrapped-around indices below ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && req[i] && (IW'(i) >= ptr)) begin
                gnt_vld = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && req[i] && (IW'(i) < ptr)) begin
                gnt_vld = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/xor_path_sched.sv
// Shares one XOR/INV datapath between NREQ requesters, one op in flight (IDLE->EXEC->RESP).
// Latency: grant in cycle t gives rsp_valid in t+2; issue interval is 3 cycles minimum.
// Backpressure: rsp held stable until rsp_ready; req_ready stays low outside IDLE. Stats via XOR_PATH_SCHED_STATS_EN.
module xor_path_sched
    import xor_path_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ*W-1:0]        req_c,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_o1,
    output logic [W-1:0]             rsp_o2,
    output logic [W-1:0]             rsp_o3,
    output logic                     busy,
    output logic [31:0]              stat_ops
);

    localparam int IW = $clog2(NREQ);

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   g_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    c_q;
    logic [W-1:0]    x_q;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic            rsp_hs;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign rsp_hs = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready = gnt;
                    state_d   = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The reset cycle must not look like an accepted request.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q <= req_a[gnt_idx*W +: W];
                        b_q <= req_b[gnt_idx*W +: W];
                        c_q <= req_c[gnt_idx*W +: W];
                        g_q <= gnt_idx;
                    end
                end
                EXEC: x_q <= a_q ^ b_q;
                RESP: begin
                    if (rsp_ready) begin
                        ptr_q <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated on RESP so the idle/reset view is all-zero rather than ~0 from the inverters.
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_valid ? g_q : '0;
    assign rsp_o1    = rsp_valid ? (x_q ^ ~c_q) : '0;
    assign rsp_o2    = rsp_valid ? c_q : '0;
    assign rsp_o3    = rsp_valid ? ~x_q : '0;
    assign busy      = (state_q != IDLE);

`ifdef XOR_PATH_SCHED_STATS_EN
    logic [31:0] ops_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
        end else if (rsp_hs) begin
            ops_q <= ops_q + 32'd1;
        end
    end

    assign stat_ops = ops_q;
`else
    assign stat_ops = '0;
`endif

endmodule

// File: doc/xor_path_sched.md
XOR_PATH_SCHED -- requirements
Module: xor_path_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing the XOR/INV datapath (2..16).
REQ-002 The block SHALL have parameter W, default 8, operand and result width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 The block SHALL have port req_ready  output  NREQ  per-requester accept, at most one bit high per cycle.
REQ-007 The block SHALL have ports req_a, req_b, req_c  input  NREQ*W  packed operands, slice i belonging to requester i.
REQ-008 The block SHALL have port rsp_valid  output  1  result available.
REQ-009 The block SHALL have port rsp_ready  input  1  result consumer accept.
REQ-010 The block SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-011 The block SHALL have ports rsp_o1, rsp_o2, rsp_o3  output  W  results.
REQ-012 The block SHALL have port busy  output  1  high when not IDLE.
REQ-013 The block SHALL have port stat_ops  output  32  completed-operation count (see Configuration).

Function
REQ-014 FSM states: IDLE, EXEC, RESP; only one operation in flight.
REQ-015 IDLE: when any req_valid is high, the grant g is the first valid index at or after pointer ptr, wrapping modulo NREQ; req_ready[g] is driven combinationally high in the same cycle; the block captures a, b, c and g, then moves to EXEC.
REQ-016 req_ready SHALL be all-zero in EXEC and RESP.
REQ-017 EXEC: register x = a ^ b; register c; move to RESP after exactly one cycle.
REQ-018 RESP: rsp_valid = 1; rsp_o1 = x ^ ~c; rsp_o2 = c; rsp_o3 = ~x; rsp_id = g.
REQ-019 All rsp_* outputs SHALL remain stable while rsp_valid && !rsp_ready.
REQ-020 On rsp_valid && rsp_ready: ptr = (g+1) mod NREQ; next state is IDLE.
REQ-021 Latency: a request handshake in cycle t SHALL produce rsp_valid in cycle t+2; minimum issue interval is 3 cycles.
REQ-022 A req_valid deasserted before grant SHALL be dropped without any state change.

Reset
REQ-023 With rst high at a clock edge: state = IDLE, ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_o1/o2/o3 = 0, busy = 0, stat_ops = 0; req_ready = 0 during the reset cycle.
REQ-024 A reset in EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-025 Macro XOR_PATH_SCHED_STATS_EN defined: stat_ops increments by 1 on each response handshake and wraps at 2^32.
REQ-026 Macro XOR_PATH_SCHED_STATS_EN undefined: stat_ops is tied to 0 and no counter logic is present.

Structure
REQ-027 The package xor_path_sched_pkg SHALL hold the state enum (IDLE/EXEC/RESP) and the default constants for NREQ and W.
REQ-028 The round-robin grant logic SHALL be a sub-module rr_arbiter: inputs are the request vector and ptr; output is a one-hot grant plus its index.

Verification
REQ-029 NREQ=4, W=8, req 2 only, a=0x0F, b=0xF0, c=0x55 at cycle t -> rsp_valid at t+2, rsp_id=2, o1=0x55, o2=0x55, o3=0x00.
REQ-030 All four req_valid held high from reset and rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-031 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout, busy=1.
REQ-032 After grant 3 completes, req 0 and req 3 both valid -> grant 0 (pointer wrap).
REQ-033 rst asserted in EXEC -> next cycle state IDLE, rsp_valid=0, busy=0, ptr=0, no response issued.
REQ-034 With XOR_PATH_SCHED_STATS_EN, 10 completed operations -> stat_ops=10; without the macro -> stat_ops=0.
